dlx_mem_stage: RTL

DLX_MEM_STAGE -- requirements
Module: dlx_mem_stage

---
 rtl/dlx_pkg.sv | 41 ++++
 rtl/dlx_mem_align.sv | 36 +++
 rtl/dlx_mem_stage.sv | 133 +++++++++++++
 3 files changed

// File: rtl/dlx_pkg.sv
// Shared types and constants for the DLX memory stage.
// Byte/halfword-free build unless DLX_MEM_BYTE_EN is defined (enables LB/LBU/SB).
package dlx_pkg;
  localparam int DLX_XLEN  = 32;
  localparam int DLX_REG_W = 5;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_LW   = 3'd1,
    OP_SW   = 3'd2,
    OP_LB   = 3'd3,
    OP_LBU  = 3'd4,
    OP_SB   = 3'd5
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } mem_state_e;

  localparam logic [1:0] EXC_NONE     = 2'd0;
  localparam logic [1:0] EXC_MISALIGN = 2'd1;
  localparam logic [1:0] EXC_TIMEOUT  = 2'd2;
  localparam logic [1:0] EXC_ILLEGAL  = 2'd3;

  function automatic logic op_legal(input mem_op_e op);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_NONE, OP_LW, OP_SW: ok = 1'b1;
`ifdef DLX_MEM_BYTE_EN
      OP_LB, OP_LBU, OP_SB:  ok = 1'b1;
`else
      OP_LB, OP_LBU, OP_SB:  ok = 1'b0;
`endif
      default:               ok = 1'b0;
    endcase
    return ok;
  endfunction
endpackage

// File: rtl/dlx_mem_align.sv
// Combinational byte-lane steering: store byte enables / data replication and
// load extraction with sign or zero extension.
module dlx_mem_align
  import dlx_pkg::*;
(
  input  logic [2:0]          op,
  input  logic [1:0]          lane,
  input  logic [DLX_XLEN-1:0] sdata,
  input  logic [DLX_XLEN-1:0] rdata,
  output logic [3:0]          be,
  output logic [DLX_XLEN-1:0] wdata,
  output logic [DLX_XLEN-1:0] ldata
);
  mem_op_e    op_e;
  logic [7:0] rbyte;

  assign op_e  = mem_op_e'(op);
  assign rbyte = rdata[{lane, 3'b000} +: 8];

  always_comb begin
    be    = 4'b0000;
    wdata = sdata;
    ldata = '0;
    case (op_e)
      OP_LW:   ldata = rdata;
      OP_LB:   ldata = {{24{rbyte[7]}}, rbyte};
      OP_LBU:  ldata = {24'h0, rbyte};
      OP_SW:   be = 4'b1111;
      OP_SB: begin
        be    = 4'b0001 << lane;
        wdata = {4{sdata[7:0]}};
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/dlx_mem_stage.sv
// DLX memory stage: IDLE/REQ/WAIT bus handshake with ack timeout and a
// registered writeback port. Byte ops gated by DLX_MEM_BYTE_EN.
module dlx_mem_stage
  import dlx_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [2:0]           in_op,
  input  logic [DLX_XLEN-1:0]  in_res,
  input  logic [DLX_XLEN-1:0]  in_sdata,
  input  logic [DLX_REG_W-1:0] in_rd,
  output logic                 stall,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [DLX_XLEN-1:0]  mem_addr,
  output logic [DLX_XLEN-1:0]  mem_wdata,
  output logic [3:0]           mem_be,
  input  logic                 mem_ack,
  input  logic [DLX_XLEN-1:0]  mem_rdata,
  output logic                 wb_valid,
  output logic [DLX_REG_W-1:0] wb_rd,
  output logic [DLX_XLEN-1:0]  wb_data,
  output logic [1:0]           exc
);
  mem_state_e           state, state_nx;
  logic [7:0]           cnt;
  logic [DLX_XLEN-1:0]  addr_q, sdata_q;
  logic [2:0]           op_q;
  logic [1:0]           lane_q;
  logic [DLX_REG_W-1:0] rd_q;

  mem_op_e              op_in;
  logic                 legal, misal, is_mem, accept;
  logic                 busy, tmo, done, is_store;
  logic [3:0]           be;
  logic [DLX_XLEN-1:0]  wdata, ldata;

  assign op_in  = mem_op_e'(in_op);
  assign legal  = op_legal(op_in);
  assign misal  = (op_in == OP_LW || op_in == OP_SW) && (in_res[1:0] != 2'b00);
  assign is_mem = (op_in != OP_NONE);
  assign accept = (state == ST_IDLE) && in_valid && legal && is_mem && !misal;

  assign busy     = (state != ST_IDLE);
  assign tmo      = busy && (cnt == 8'(ACK_TIMEOUT));
  assign done     = busy && !tmo && mem_ack;
  assign is_store = (mem_op_e'(op_q) == OP_SW) || (mem_op_e'(op_q) == OP_SB);

  // Stall drops in the ack/timeout cycle so upstream advances at that edge and
  // can present its next instruction in the completion cycle.
  assign stall     = accept || (busy && !done && !tmo);
  assign mem_req   = busy && !tmo;
  assign mem_we    = mem_req && is_store;
  assign mem_be    = mem_req ? be : 4'b0000;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata;

  dlx_mem_align u_align (
    .op    (op_q),
    .lane  (lane_q),
    .sdata (sdata_q),
    .rdata (mem_rdata),
    .be    (be),
    .wdata (wdata),
    .ldata (ldata)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:         if (accept) state_nx = ST_REQ;
      ST_REQ, ST_WAIT: state_nx = (done || tmo) ? ST_IDLE : ST_WAIT;
      default:         state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt     <= '0;
      addr_q  <= '0;
      sdata_q <= '0;
      op_q    <= '0;
      lane_q  <= '0;
      rd_q    <= '0;
    end else if (accept) begin
      cnt     <= '0;
      addr_q  <= {in_res[DLX_XLEN-1:2], 2'b00};
      sdata_q <= in_sdata;
      op_q    <= in_op;
      lane_q  <= in_res[1:0];
      rd_q    <= in_rd;
    end else if (busy && !done && !tmo) begin
      cnt <= cnt + 8'd1;
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      exc      <= EXC_NONE;
    end else begin
      wb_valid <= 1'b0;
      if ((state == ST_IDLE) && in_valid && !accept) begin
        wb_valid <= 1'b1;
        // Only NONE reaches the last branch: legal, aligned, not a memory op.
        if (!legal) begin
          wb_rd <= '0; wb_data <= '0; exc <= EXC_ILLEGAL;
        end else if (misal) begin
          wb_rd <= '0; wb_data <= '0; exc <= EXC_MISALIGN;
        end else begin
          wb_rd <= in_rd; wb_data <= in_res; exc <= EXC_NONE;
        end
      end else if (done) begin
        wb_valid <= 1'b1;
        wb_rd    <= is_store ? '0 : rd_q;
        wb_data  <= is_store ? '0 : ldata;
        exc      <= EXC_NONE;
      end else if (tmo) begin
        wb_valid <= 1'b1;
        wb_rd    <= '0;
        wb_data  <= '0;
        exc      <= EXC_TIMEOUT;
      end
    end
endmodule
